// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: grants the single memory port to fetch or to the
// data stage, runs one req/ack transaction per grant and reports done/stall.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAXSTARVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_readmem,
  input  logic              dm_writemem,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (MAXSTARVE < 1) ? 1 : $clog2(MAXSTARVE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_dm_req;
  logic              w_starved;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic              w_complete;

  logic [CW-1:0]     r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_done;
  logic              r_dm_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  // Arbitration and next state; a store with readmem also high is still a store
  always_comb begin
    w_dm_req   = dm_readmem | dm_writemem;
    w_starved  = (r_starve_cnt == CW'(MAXSTARVE));
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_complete = 1'b0;
    w_next     = r_state;
    case (r_state)
      IDLE: begin
        if (if_req && (!w_dm_req || w_starved)) begin
          w_grant_if = 1'b1;
          w_next     = IF_BUSY;
        end else if (w_dm_req) begin
          w_grant_dm = 1'b1;
          w_next     = DM_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ack) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory-side request registers, starvation counter and returned data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_done    <= 1'b0;
      r_dm_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      if (w_grant_if) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_addr   <= if_addr;
        r_starve_cnt <= '0;
      end else if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_writemem;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        if (if_req && !w_starved) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else if (w_complete) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        if (r_state == IF_BUSY) begin
          r_if_rdata <= mem_rdata;
          r_if_done  <= 1'b1;
        end else begin
          r_dm_rdata <= mem_rdata;
          r_dm_done  <= 1'b1;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_done   = r_if_done;
  assign dm_done   = r_dm_done;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  // Stalls release in the done cycle so the stage can advance that same cycle
  assign if_stall  = if_req & ~r_if_done;
  assign dm_stall  = w_dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model of the arbitration and handshake rules.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          dm_readmem = 1'b0, dm_writemem = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_done, dm_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAXSTARVE(MS)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_readmem(dm_readmem), .dm_writemem(dm_writemem), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = port free, 1 = fetch holds it, 2 = data holds it
  int            m_owner = 0;
  int            m_starve = 0;
  logic          m_req = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
  logic          m_if_done = 1'b0, m_dm_done = 1'b0;
  int            grant_log[$];

  task automatic model_edge();
    logic want_dm;
    want_dm = dm_readmem | dm_writemem;
    if (reset) begin
      m_owner = 0; m_starve = 0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_dm_rdata = '0; m_if_done = 0; m_dm_done = 0;
      return;
    end
    m_if_done = 0;
    m_dm_done = 0;
    if (m_owner == 0) begin
      if (if_req && (!want_dm || m_starve == MS)) begin
        m_owner = 1; m_req = 1; m_we = 0; m_addr = if_addr; m_starve = 0;
        grant_log.push_back(1);
      end else if (want_dm) begin
        m_owner = 2; m_req = 1; m_we = dm_writemem; m_addr = dm_addr; m_wdata = dm_wdata;
        if (if_req) m_starve = (m_starve + 1 > MS) ? MS : m_starve + 1;
        grant_log.push_back(2);
      end
    end else if (mem_ack) begin
      if (m_owner == 1) begin m_if_rdata = mem_rdata; m_if_done = 1; end
      else              begin m_dm_rdata = mem_rdata; m_dm_done = 1; end
      m_req = 0;
      m_owner = 0;
    end
  endtask

  task automatic check_regs();
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("if_done", 32'(if_done), 32'(m_if_done));
    chk("dm_done", 32'(dm_done), 32'(m_dm_done));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    if (m_req) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    #1;
    chk("if_stall", 32'(if_stall), 32'(if_req & ~m_if_done));
    chk("dm_stall", 32'(dm_stall), 32'((dm_readmem | dm_writemem) & ~m_dm_done));
    @(posedge clock);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_readmem = 0; dm_writemem = 0; mem_ack = 0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    chk("rst_stalls", 32'({if_stall, dm_stall}), 32'd0);

    // Fetch alone: grant at edge 0, ack in cycle 2, done in cycle 3
    if_req = 1; if_addr = 32'h100;
    tick();
    chk("f_req_c1", 32'(mem_req), 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_we", 32'(mem_we), 32'd0);
    tick();
    chk("f_req_c2", 32'(mem_req), 32'd1);
    chk("f_stall_c2", 32'(if_stall), 32'd1);
    mem_ack = 1; mem_rdata = 32'h00A00093;
    tick();
    chk("f_done", 32'(if_done), 32'd1);
    chk("f_rdata", if_rdata, 32'h00A00093);
    chk("f_req_c3", 32'(mem_req), 32'd0);
    idle_inputs();
    tick();
    chk("f_done_clr", 32'(if_done), 32'd0);

    // Store with a one-cycle ack
    dm_writemem = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    tick();
    chk("s_we", 32'(mem_we), 32'd1);
    chk("s_addr", mem_addr, 32'h40);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    tick();
    chk("s_done", 32'(dm_done), 32'd1);
    chk("s_if_done", 32'(if_done), 32'd0);
    idle_inputs();
    tick();

    // Simultaneous: data first, fetch granted in the dm_done cycle
    if_req = 1; if_addr = 32'h200; dm_readmem = 1; dm_addr = 32'h80;
    tick();
    chk("sim_dm_first", mem_addr, 32'h80);
    mem_ack = 1; mem_rdata = 32'h11112222;
    tick();
    chk("sim_dm_done", 32'(dm_done), 32'd1);
    dm_readmem = 0; mem_ack = 0;
    tick();
    chk("sim_if_grant", mem_addr, 32'h200);
    chk("sim_if_req", 32'(mem_req), 32'd1);
    mem_ack = 1; mem_rdata = 32'h33334444;
    tick();
    chk("sim_if_done", 32'(if_done), 32'd1);
    idle_inputs();
    tick();

    // Starvation: both requests held, memory acks every busy cycle
    grant_log.delete();
    if_req = 1; if_addr = 32'h300; dm_readmem = 1; dm_addr = 32'hC0;
    for (int i = 0; i < 24; i++) begin
      mem_ack = (m_owner != 0);
      mem_rdata = $urandom();
      tick();
    end
    chk("starve_ngrants_ok", 32'(grant_log.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      chk($sformatf("starve_g%0d", i), grant_log[i], (i % 5 == 4) ? 32'd1 : 32'd2);
    idle_inputs();
    tick();
    tick();

    // Reset while data holds the port, stray ack two cycles later
    dm_readmem = 1; dm_addr = 32'hF0;
    tick();
    chk("r_busy", 32'(mem_req), 32'd1);
    reset = 1; dm_readmem = 0;
    tick();
    reset = 0;
    chk("r_mem_req", 32'(mem_req), 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_rdata", if_rdata | dm_rdata, 32'd0);
    tick();
    mem_ack = 1; mem_rdata = 32'h99999999;
    tick();
    mem_ack = 0;
    chk("r_no_done", 32'({if_done, dm_done}), 32'd0);
    chk("r_stray_rdata", dm_rdata, 32'd0);

    // Spurious ack while idle
    mem_ack = 1; mem_rdata = 32'hBADC0DE0;
    tick();
    mem_ack = 0;
    chk("sp_req", 32'(mem_req), 32'd0);
    chk("sp_done", 32'({if_done, dm_done}), 32'd0);
    chk("sp_rdata", if_rdata | dm_rdata, 32'd0);
    tick();

    // Random traffic, including occasional reset and spurious acks
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      if_req      = ($urandom_range(0, 2) != 0);
      dm_readmem  = ($urandom_range(0, 2) == 0);
      dm_writemem = ($urandom_range(0, 3) == 0);
      if_addr     = $urandom();
      dm_addr     = $urandom();
      dm_wdata    = $urandom();
      mem_rdata   = $urandom();
      mem_ack     = (m_owner != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
